// File: rtl/axi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_pkg : response codes, burst encoding and master state type       |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package axi_pkg;

  localparam logic [1:0] RESP_OKAY       = 2'b00;
  localparam logic [1:0] RESP_SLVERR     = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam int unsigned AXI_4K_BOUNDARY = 4096;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5
  } mst_state_e;

  function automatic int unsigned bytes_per_beat(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_beat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_beat_counter : 8-bit burst beat counter with last-beat compare   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module axi_beat_counter (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       load_i,
  input  logic       inc_i,
  input  logic [7:0] len_i,
  output logic [7:0] cnt_o,
  output logic       is_last_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_last_o = (cnt_q == len_i);

endmodule
`default_nettype wire

// File: rtl/axi4_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4_burst_master : one command -> one INCR AXI4 read/write burst    |
// | Optional: AXI_MASTER_4K_CHECK_EN rejects bursts crossing 4 KB        |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module axi4_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 512
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_write_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [7:0]              cmd_len_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic                    rd_last_o,
  output logic                    rd_valid_o,
  input  logic                    rd_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    done_err_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr_o,
  output logic [7:0]              m_axi_awlen_o,
  output logic [1:0]              m_axi_awburst_o,
  output logic                    m_axi_awvalid_o,
  input  logic                    m_axi_awready_i,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb_o,
  output logic                    m_axi_wlast_o,
  output logic                    m_axi_wvalid_o,
  input  logic                    m_axi_wready_i,
  input  logic [1:0]              m_axi_bresp_i,
  input  logic                    m_axi_bvalid_i,
  output logic                    m_axi_bready_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr_o,
  output logic [7:0]              m_axi_arlen_o,
  output logic [1:0]              m_axi_arburst_o,
  output logic                    m_axi_arvalid_o,
  input  logic                    m_axi_arready_i,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata_i,
  input  logic [1:0]              m_axi_rresp_i,
  input  logic                    m_axi_rlast_i,
  input  logic                    m_axi_rvalid_i,
  output logic                    m_axi_rready_o
);

  mst_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;
  logic                  done_err_q, done_err_d;

  logic       cmd_fire, w_fire, r_fire, reject;
  logic       beat_last, rd_beat_err;
  logic [7:0] beat_cnt;

  assign cmd_fire    = (state_q == ST_IDLE) && cmd_valid_i;
  assign w_fire      = (state_q == ST_W) && wr_valid_i && m_axi_wready_i;
  assign r_fire      = (state_q == ST_R) && m_axi_rvalid_i && rd_ready_i;
  // A beat is bad on a non-OKAY response or an RLAST that disagrees with our own count
  assign rd_beat_err = (m_axi_rresp_i != RESP_OKAY) || (m_axi_rlast_i != beat_last);

`ifdef AXI_MASTER_4K_CHECK_EN
  localparam int unsigned BYTES_PER_BEAT = bytes_per_beat(DATA_WIDTH);
  logic [31:0] span_end;
  assign span_end = 32'(cmd_addr_i[11:0]) + (32'(cmd_len_i) + 32'd1) * 32'(BYTES_PER_BEAT);
  assign reject   = cmd_fire && (span_end > 32'(AXI_4K_BOUNDARY));
`else
  assign reject   = 1'b0;
`endif

  axi_beat_counter u_beat_counter (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load_i    (cmd_fire),
    .inc_i     (w_fire | r_fire),
    .len_i     (len_q),
    .cnt_o     (beat_cnt),
    .is_last_o (beat_last)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cmd_fire && !reject) state_d = cmd_write_i ? ST_AW : ST_AR;
      ST_AW:   if (m_axi_awready_i)     state_d = ST_W;
      ST_W:    if (w_fire && beat_last) state_d = ST_B;
      ST_B:    if (m_axi_bvalid_i)      state_d = ST_IDLE;
      ST_AR:   if (m_axi_arready_i)     state_d = ST_R;
      ST_R:    if (r_fire && beat_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    len_d      = len_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    if (cmd_fire) begin
      addr_d = cmd_addr_i;
      len_d  = cmd_len_i;
      err_d  = 1'b0;
    end
    if (reject) begin
      done_d     = 1'b1;
      done_err_d = 1'b1;
    end
    if ((state_q == ST_B) && m_axi_bvalid_i) begin
      done_d     = 1'b1;
      done_err_d = (m_axi_bresp_i != RESP_OKAY);
    end
    if (r_fire) begin
      err_d = err_q | rd_beat_err;
      if (beat_last) begin
        done_d     = 1'b1;
        done_err_d = err_q | rd_beat_err;
      end
    end
  end

  always_comb begin
    cmd_ready_o     = 1'b0;
    m_axi_awvalid_o = 1'b0;
    m_axi_wvalid_o  = 1'b0;
    wr_ready_o      = 1'b0;
    m_axi_bready_o  = 1'b0;
    m_axi_arvalid_o = 1'b0;
    m_axi_rready_o  = 1'b0;
    rd_valid_o      = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready_o = 1'b1;
      ST_AW:   m_axi_awvalid_o = 1'b1;
      ST_W: begin
        m_axi_wvalid_o = wr_valid_i;
        wr_ready_o     = m_axi_wready_i;
      end
      ST_B:    m_axi_bready_o = 1'b1;
      ST_AR:   m_axi_arvalid_o = 1'b1;
      ST_R: begin
        rd_valid_o     = m_axi_rvalid_i;
        m_axi_rready_o = rd_ready_i;
      end
      default: ;
    endcase
  end

  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awlen_o   = len_q;
  assign m_axi_awburst_o = AXI_BURST_INCR;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arlen_o   = len_q;
  assign m_axi_arburst_o = AXI_BURST_INCR;
  assign m_axi_wdata_o   = wr_data_i;
  assign m_axi_wstrb_o   = wr_strb_i;
  assign m_axi_wlast_o   = beat_last;
  assign rd_data_o       = m_axi_rdata_i;
  assign rd_last_o       = (beat_cnt == len_q);
  assign busy_o          = (state_q != ST_IDLE);
  assign done_o          = done_q;
  assign done_err_o      = done_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_burst_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi4_burst_master : randomized bench with AXI slave memory model  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_axi4_burst_master;
  import axi_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 512;
  localparam int BPB = DW / 8;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [7:0]    cmd_len_i = '0;
  logic [DW-1:0] wr_data_i = '0;
  logic [BPB-1:0] wr_strb_i = '0;
  logic          wr_valid_i = 1'b0, wr_ready_o;
  logic [DW-1:0] rd_data_o;
  logic          rd_last_o, rd_valid_o, rd_ready_i = 1'b0;
  logic          busy_o, done_o, done_err_o;
  logic [AW-1:0] m_axi_awaddr_o, m_axi_araddr_o;
  logic [7:0]    m_axi_awlen_o, m_axi_arlen_o;
  logic [1:0]    m_axi_awburst_o, m_axi_arburst_o;
  logic          m_axi_awvalid_o, m_axi_awready_i = 1'b0;
  logic [DW-1:0] m_axi_wdata_o;
  logic [BPB-1:0] m_axi_wstrb_o;
  logic          m_axi_wlast_o, m_axi_wvalid_o, m_axi_wready_i = 1'b0;
  logic [1:0]    m_axi_bresp_i = 2'b00;
  logic          m_axi_bvalid_i = 1'b0, m_axi_bready_o;
  logic          m_axi_arvalid_o, m_axi_arready_i = 1'b0;
  logic [DW-1:0] m_axi_rdata_i = '0;
  logic [1:0]    m_axi_rresp_i = 2'b00;
  logic          m_axi_rlast_i = 1'b0, m_axi_rvalid_i = 1'b0, m_axi_rready_o;

  always #5 aclk = ~aclk;

  axi4_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .busy_o(busy_o), .done_o(done_o), .done_err_o(done_err_o),
    .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awlen_o(m_axi_awlen_o), .m_axi_awburst_o(m_axi_awburst_o),
    .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
    .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wstrb_o(m_axi_wstrb_o), .m_axi_wlast_o(m_axi_wlast_o),
    .m_axi_wvalid_o(m_axi_wvalid_o), .m_axi_wready_i(m_axi_wready_i),
    .m_axi_bresp_i(m_axi_bresp_i), .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o),
    .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arlen_o(m_axi_arlen_o), .m_axi_arburst_o(m_axi_arburst_o),
    .m_axi_arvalid_o(m_axi_arvalid_o), .m_axi_arready_i(m_axi_arready_i),
    .m_axi_rdata_i(m_axi_rdata_i), .m_axi_rresp_i(m_axi_rresp_i), .m_axi_rlast_i(m_axi_rlast_i),
    .m_axi_rvalid_i(m_axi_rvalid_i), .m_axi_rready_o(m_axi_rready_o)
  );

  int tests = 0;
  int fails = 0;

  // Engine-side write payload, and what each side observed during the last transaction
  logic [DW-1:0]  wr_q[$];
  logic [BPB-1:0] strb_q[$];
  logic [DW-1:0]  rd_q[$];
  bit             rdlast_q[$];
  bit             wlast_q[$];
  logic [DW-1:0]  slv_mem[int];
  logic [DW-1:0]  ref_mem[int];
  int             done_cyc, hs_cyc, n_done, aw_cnt, ar_cnt, w_viol, addr_bad;
  logic           done_err_seen;
  bit             aborted;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BPB-1:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BPB; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic void ref_store(input logic [AW-1:0] addr);
    for (int i = 0; i < wr_q.size(); i++) begin
      int idx;
      idx = int'(addr >> 6) + i;
      ref_mem[idx] = merge(ref_mem.exists(idx) ? ref_mem[idx] : '0, wr_q[i], strb_q[i]);
    end
  endfunction

  function automatic int rd_data_bad(input logic [AW-1:0] addr);
    int bad;
    bad = 0;
    for (int i = 0; i < rd_q.size(); i++) begin
      int idx;
      idx = int'(addr >> 6) + i;
      if (rd_q[i] !== (ref_mem.exists(idx) ? ref_mem[idx] : '0)) bad++;
    end
    return bad;
  endfunction

  // Positions where the last flag disagrees with "only on the final beat of n"
  function automatic int last_bad(input bit use_rd, input int n);
    bit q[$];
    int bad;
    if (use_rd) q = rdlast_q; else q = wlast_q;
    bad = (q.size() != n) ? 1 : 0;
    for (int i = 0; i < q.size(); i++) if (q[i] != (i == n - 1)) bad++;
    return bad;
  endfunction

  task automatic idle_inputs();
    cmd_valid_i = 0; wr_valid_i = 0; rd_ready_i = 0;
    m_axi_awready_i = 0; m_axi_wready_i = 0; m_axi_bvalid_i = 0;
    m_axi_arready_i = 0; m_axi_rvalid_i = 0; m_axi_rlast_i = 0;
  endtask

  // One command driven cycle by cycle: engine side plus an AXI slave memory.
  // Handshakes are decided from values sampled 1 time unit after the negedge.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [7:0] len,
                         input bit stall, input logic [1:0] bresp, input int early,
                         input int abort_beat);
    bit cmd_done, w_act, b_pend, r_act;
    int eng_wb, slv_wb, slv_rb;
    logic [AW-1:0] s_addr;
    logic [7:0] s_len;
    cmd_done = 0; w_act = 0; b_pend = 0; r_act = 0;
    eng_wb = 0; slv_wb = 0; slv_rb = 0; s_addr = '0; s_len = '0;
    done_cyc = -1; hs_cyc = -1; n_done = 0; done_err_seen = 0;
    aw_cnt = 0; ar_cnt = 0; w_viol = 0; addr_bad = 0; aborted = 0;
    rd_q.delete(); rdlast_q.delete(); wlast_q.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge aclk);
      if (abort_beat >= 0 && w_act && eng_wb == abort_beat) begin
        aresetn = 0;
        #1;
        aborted = 1;
        return;
      end
      cmd_valid_i = !cmd_done; cmd_write_i = wr; cmd_addr_i = addr; cmd_len_i = len;
      wr_valid_i = wr && (eng_wb < wr_q.size()) && (!stall || $urandom_range(0, 2) != 0);
      wr_data_i  = (eng_wb < wr_q.size()) ? wr_q[eng_wb] : '0;
      wr_strb_i  = (eng_wb < strb_q.size()) ? strb_q[eng_wb] : '0;
      rd_ready_i = !stall || $urandom_range(0, 2) != 0;
      m_axi_awready_i = !stall || $urandom_range(0, 1) != 0;
      m_axi_arready_i = !stall || $urandom_range(0, 1) != 0;
      m_axi_wready_i  = w_act && (!stall || $urandom_range(0, 2) != 0);
      m_axi_bvalid_i  = b_pend;
      m_axi_bresp_i   = bresp;
      m_axi_rvalid_i  = r_act && (!stall || $urandom_range(0, 2) != 0);
      m_axi_rdata_i   = slv_mem.exists(int'(s_addr >> 6) + slv_rb) ? slv_mem[int'(s_addr >> 6) + slv_rb] : '0;
      m_axi_rlast_i   = (early >= 0) ? (slv_rb == early) : (slv_rb == int'(s_len));
      m_axi_rresp_i   = RESP_OKAY;
      #1;
      if (done_o) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = cyc; done_err_seen = done_err_o; end
      end
      if (m_axi_bvalid_i && m_axi_bready_o) begin b_pend = 0; hs_cyc = cyc; end
      if (rd_valid_o && rd_ready_i) begin rd_q.push_back(rd_data_o); rdlast_q.push_back(rd_last_o); end
      if (m_axi_rvalid_i && m_axi_rready_o) begin
        if (slv_rb == int'(s_len)) begin r_act = 0; hs_cyc = cyc; end
        slv_rb++;
      end
      if (m_axi_wvalid_o && !w_act) w_viol++;
      if (wr_valid_i && wr_ready_o) eng_wb++;
      if (w_act && m_axi_wvalid_o && m_axi_wready_i) begin
        int idx;
        idx = int'(s_addr >> 6) + slv_wb;
        slv_mem[idx] = merge(slv_mem.exists(idx) ? slv_mem[idx] : '0, m_axi_wdata_o, m_axi_wstrb_o);
        wlast_q.push_back(m_axi_wlast_o);
        if (slv_wb == int'(s_len)) begin w_act = 0; b_pend = 1; end
        slv_wb++;
      end
      if (m_axi_awvalid_o && (m_axi_awaddr_o !== addr || m_axi_awlen_o !== len)) addr_bad++;
      if (m_axi_arvalid_o && (m_axi_araddr_o !== addr || m_axi_arlen_o !== len)) addr_bad++;
      if (m_axi_awvalid_o && m_axi_awready_i) begin
        aw_cnt++; w_act = 1; s_addr = m_axi_awaddr_o; s_len = m_axi_awlen_o; slv_wb = 0;
      end
      if (m_axi_arvalid_o && m_axi_arready_i) begin
        ar_cnt++; r_act = 1; s_addr = m_axi_araddr_o; s_len = m_axi_arlen_o; slv_rb = 0;
      end
      if (cmd_valid_i && cmd_ready_o) cmd_done = 1;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    #1;
    tests++; if ({cmd_ready_o, busy_o} !== 2'b10) begin fails++;
      $display("FAIL reset_ready_busy: got %b want 10", {cmd_ready_o, busy_o}); end
    tests++; if ({m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o, m_axi_arvalid_o, m_axi_rready_o,
                  rd_valid_o, done_o, done_err_o} !== 8'h00) begin fails++;
      $display("FAIL reset_valids: got %b want 00000000", {m_axi_awvalid_o, m_axi_wvalid_o,
               m_axi_bready_o, m_axi_arvalid_o, m_axi_rready_o, rd_valid_o, done_o, done_err_o}); end
    @(negedge aclk);
    aresetn = 1;
  endtask

  task automatic test_write_read();
    logic [31:0] w;
    wr_q.delete(); strb_q.delete();
    for (int i = 0; i < 4; i++) begin
      w = 32'h1000_0000 + 32'(i);
      wr_q.push_back({16{w}}); strb_q.push_back('1);
    end
    ref_store(32'h1000);
    run_txn(1, 32'h1000, 8'd3, 0, RESP_OKAY, -1, -1);
    tests++; if (aw_cnt !== 1) begin fails++; $display("FAIL wr3_aw_count: got %0d want 1", aw_cnt); end
    tests++; if (last_bad(0, 4) !== 0) begin fails++; $display("FAIL wr3_wlast: got %0d bad want 0", last_bad(0, 4)); end
    tests++; if (w_viol + addr_bad !== 0) begin fails++;
      $display("FAIL wr3_protocol: got %0d violations want 0", w_viol + addr_bad); end
    tests++; if (done_err_seen !== 1'b0) begin fails++; $display("FAIL wr3_done_err: got %b want 0", done_err_seen); end
    tests++; if (done_cyc !== hs_cyc + 1 || n_done !== 1) begin fails++;
      $display("FAIL wr3_done_timing: got cyc %0d x%0d want cyc %0d x1", done_cyc, n_done, hs_cyc + 1); end
    wr_q.delete(); strb_q.delete();
    run_txn(0, 32'h1000, 8'd3, 0, RESP_OKAY, -1, -1);
    tests++; if (rd_q.size() !== 4) begin fails++; $display("FAIL rd3_beats: got %0d want 4", rd_q.size()); end
    tests++; if (rd_data_bad(32'h1000) !== 0) begin fails++;
      $display("FAIL rd3_data: got %0d bad beats want 0", rd_data_bad(32'h1000)); end
    tests++; if (last_bad(1, 4) !== 0) begin fails++; $display("FAIL rd3_last: got %0d bad want 0", last_bad(1, 4)); end
    tests++; if (done_err_seen !== 1'b0 || done_cyc !== hs_cyc + 1) begin fails++;
      $display("FAIL rd3_done: got err %b cyc %0d want err 0 cyc %0d", done_err_seen, done_cyc, hs_cyc + 1); end
  endtask

  task automatic test_len0();
    wr_q.delete(); strb_q.delete();
    wr_q.push_back(rand_beat()); strb_q.push_back('1);
    ref_store(32'h40);
    run_txn(1, 32'h40, 8'd0, 0, RESP_OKAY, -1, -1);
    tests++; if (wlast_q.size() !== 1 || last_bad(0, 1) !== 0) begin fails++;
      $display("FAIL len0_wlast: got %0d beats %0d bad want 1 beat 0 bad", wlast_q.size(), last_bad(0, 1)); end
    tests++; if (done_cyc !== hs_cyc + 1 || done_err_seen !== 1'b0) begin fails++;
      $display("FAIL len0_wr_done: got cyc %0d err %b want cyc %0d err 0", done_cyc, done_err_seen, hs_cyc + 1); end
    wr_q.delete(); strb_q.delete();
    run_txn(0, 32'h40, 8'd0, 0, RESP_OKAY, -1, -1);
    tests++; if (rd_q.size() !== 1 || last_bad(1, 1) !== 0 || rd_data_bad(32'h40) !== 0) begin fails++;
      $display("FAIL len0_rd: got %0d beats last_bad %0d data_bad %0d want 1 0 0",
               rd_q.size(), last_bad(1, 1), rd_data_bad(32'h40)); end
    tests++; if (done_cyc !== hs_cyc + 1 || n_done !== 1) begin fails++;
      $display("FAIL len0_rd_done: got cyc %0d x%0d want cyc %0d x1", done_cyc, n_done, hs_cyc + 1); end
  endtask

  task automatic test_random_stalls();
    logic [AW-1:0] a;
    for (int it = 0; it < 3; it++) begin
      a = 32'h2000 + 32'($urandom_range(0, 47)) * 32'd64;
      wr_q.delete(); strb_q.delete();
      for (int i = 0; i < 16; i++) begin
        wr_q.push_back(rand_beat()); strb_q.push_back({$urandom(), $urandom()});
      end
      ref_store(a);
      run_txn(1, a, 8'd15, 1, RESP_OKAY, -1, -1);
      tests++; if (wlast_q.size() !== 16 || last_bad(0, 16) !== 0 || w_viol + addr_bad !== 0) begin fails++;
        $display("FAIL rand_wr_%0d: got %0d beats last_bad %0d viol %0d want 16 0 0",
                 it, wlast_q.size(), last_bad(0, 16), w_viol + addr_bad); end
      tests++; if (done_cyc !== hs_cyc + 1 || done_err_seen !== 1'b0) begin fails++;
        $display("FAIL rand_wr_done_%0d: got cyc %0d err %b want cyc %0d err 0", it, done_cyc, done_err_seen, hs_cyc + 1); end
      wr_q.delete(); strb_q.delete();
      run_txn(0, a, 8'd15, 1, RESP_OKAY, -1, -1);
      tests++; if (rd_q.size() !== 16 || rd_data_bad(a) !== 0) begin fails++;
        $display("FAIL rand_rd_data_%0d: got %0d beats %0d bad want 16 0", it, rd_q.size(), rd_data_bad(a)); end
      tests++; if (last_bad(1, 16) !== 0 || done_err_seen !== 1'b0 || done_cyc !== hs_cyc + 1) begin fails++;
        $display("FAIL rand_rd_done_%0d: got last_bad %0d err %b cyc %0d want 0 0 %0d",
                 it, last_bad(1, 16), done_err_seen, done_cyc, hs_cyc + 1); end
    end
  endtask

  task automatic test_errors();
    wr_q.delete(); strb_q.delete();
    for (int i = 0; i < 4; i++) begin wr_q.push_back(rand_beat()); strb_q.push_back('1); end
    ref_store(32'h3000);
    run_txn(1, 32'h3000, 8'd3, 0, RESP_SLVERR, -1, -1);
    tests++; if (done_err_seen !== 1'b1 || done_cyc !== hs_cyc + 1) begin fails++;
      $display("FAIL bresp_err: got err %b cyc %0d want err 1 cyc %0d", done_err_seen, done_cyc, hs_cyc + 1); end
    wr_q.delete(); strb_q.delete();
    run_txn(0, 32'h3000, 8'd3, 0, RESP_OKAY, 1, -1);
    tests++; if (done_err_seen !== 1'b1 || done_cyc !== hs_cyc + 1 || n_done !== 1) begin fails++;
      $display("FAIL early_rlast_err: got err %b cyc %0d x%0d want err 1 cyc %0d x1",
               done_err_seen, done_cyc, n_done, hs_cyc + 1); end
    tests++; if (rd_q.size() !== 4 || rd_data_bad(32'h3000) !== 0 || last_bad(1, 4) !== 0) begin fails++;
      $display("FAIL early_rlast_beats: got %0d beats data_bad %0d last_bad %0d want 4 0 0",
               rd_q.size(), rd_data_bad(32'h3000), last_bad(1, 4)); end
    run_txn(0, 32'h3000, 8'd3, 0, RESP_OKAY, -1, -1);
    tests++; if (done_err_seen !== 1'b0) begin fails++; $display("FAIL err_cleared: got %b want 0", done_err_seen); end
  endtask

  task automatic test_4k();
    wr_q.delete(); strb_q.delete();
    for (int i = 0; i < 2; i++) begin wr_q.push_back(rand_beat()); strb_q.push_back('1); end
    run_txn(1, 32'h0FC0, 8'd1, 0, RESP_OKAY, -1, -1);
`ifdef AXI_MASTER_4K_CHECK_EN
    tests++; if (aw_cnt !== 0 || wlast_q.size() !== 0) begin fails++;
      $display("FAIL 4k_no_traffic: got aw %0d w %0d want 0 0", aw_cnt, wlast_q.size()); end
    tests++; if (done_err_seen !== 1'b1 || done_cyc !== 1 || n_done !== 1) begin fails++;
      $display("FAIL 4k_done: got err %b cyc %0d x%0d want err 1 cyc 1 x1", done_err_seen, done_cyc, n_done); end
`else
    ref_store(32'h0FC0);
    tests++; if (aw_cnt !== 1 || last_bad(0, 2) !== 0 || addr_bad !== 0) begin fails++;
      $display("FAIL 4k_issued: got aw %0d last_bad %0d addr_bad %0d want 1 0 0", aw_cnt, last_bad(0, 2), addr_bad); end
    tests++; if (done_err_seen !== 1'b0 || done_cyc !== hs_cyc + 1) begin fails++;
      $display("FAIL 4k_done: got err %b cyc %0d want err 0 cyc %0d", done_err_seen, done_cyc, hs_cyc + 1); end
`endif
  endtask

  task automatic test_reset_mid_burst();
    wr_q.delete(); strb_q.delete();
    for (int i = 0; i < 4; i++) begin wr_q.push_back(rand_beat()); strb_q.push_back('1); end
    run_txn(1, 32'h500, 8'd3, 0, RESP_OKAY, -1, 2);
    tests++; if (aborted !== 1'b1) begin fails++; $display("FAIL midrst_reached: got %b want 1", aborted); end
    tests++; if ({m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o, m_axi_arvalid_o, m_axi_rready_o,
                  rd_valid_o, wr_ready_o, done_o, busy_o} !== 9'h000) begin fails++;
      $display("FAIL midrst_valids: got %b want 000000000", {m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o,
               m_axi_arvalid_o, m_axi_rready_o, rd_valid_o, wr_ready_o, done_o, busy_o}); end
    idle_inputs();
    @(negedge aclk);
    aresetn = 1;
    #1;
    tests++; if ({cmd_ready_o, busy_o} !== 2'b10) begin fails++;
      $display("FAIL midrst_release: got %b want 10", {cmd_ready_o, busy_o}); end
    wr_q.delete(); strb_q.delete();
    run_txn(0, 32'h40, 8'd0, 0, RESP_OKAY, -1, -1);
    tests++; if (rd_q.size() !== 1 || rd_data_bad(32'h40) !== 0 || done_err_seen !== 1'b0) begin fails++;
      $display("FAIL midrst_recover: got %0d beats data_bad %0d err %b want 1 0 0",
               rd_q.size(), rd_data_bad(32'h40), done_err_seen); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge aclk);
    test_reset();
    test_write_read();
    test_len0();
    test_random_stalls();
    test_errors();
    test_4k();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
